// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// UART_ARB_CKSUM_EN selects 3-byte packets (cmd, data, checksum) instead of 2.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} arb_state_t;

    localparam int NUM_CLIENTS = 2;

`ifdef UART_ARB_CKSUM_EN
    localparam logic [1:0] PKT_LAST = 2'd2;
`else
    localparam logic [1:0] PKT_LAST = 2'd1;
`endif

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin selector; combinational, the last_owner register lives in the parent.
module uart_rr_arb
    import uart_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   last_owner,
    output logic                   valid,
    output logic                   winner
);

    always_comb begin
        valid  = |req;
        // On a tie the client that did not go last wins; otherwise the sole requester.
        winner = (req == 2'b11) ? ~last_owner : req[1];
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Two-client round-robin arbiter and byte sequencer in front of the shared UART_tx.
// UART_ARB_CKSUM_EN appends a (cmd + data) mod 256 checksum byte to every packet.
module uart_tx_arb
    import uart_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [7:0]             cmd0,
    input  logic [7:0]             data0,
    input  logic [7:0]             cmd1,
    input  logic [7:0]             data1,
    output logic [NUM_CLIENTS-1:0] gnt,
    output logic [NUM_CLIENTS-1:0] cmplt,
    output logic                   busy,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done
);

    arb_state_t state;
    logic [7:0] pkt_cmd;
    logic [7:0] pkt_data;
    logic [1:0] byte_idx;
    logic       owner;
    logic       last_owner;
    logic       arb_valid;
    logic       arb_winner;
    logic [7:0] win_cmd;
    logic [7:0] win_data;
    logic [7:0] next_byte;

    uart_rr_arb u_rr_arb (
        .req        (req),
        .last_owner (last_owner),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign win_cmd  = arb_winner ? cmd1  : cmd0;
    assign win_data = arb_winner ? data1 : data0;
    assign busy     = (state != IDLE);

    // Byte that follows byte_idx in the latched packet.
    always_comb begin
`ifdef UART_ARB_CKSUM_EN
        next_byte = (byte_idx == 2'd0) ? pkt_data : pkt_cmd + pkt_data;
`else
        next_byte = pkt_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pkt_cmd    <= 8'h00;
            pkt_data   <= 8'h00;
            byte_idx   <= 2'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            gnt        <= '0;
            cmplt      <= '0;
            trmt       <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            gnt   <= '0;
            cmplt <= '0;
            trmt  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        pkt_cmd    <= win_cmd;
                        pkt_data   <= win_data;
                        owner      <= arb_winner;
                        last_owner <= arb_winner;
                        byte_idx   <= 2'd0;
                        gnt        <= arb_winner ? 2'b10 : 2'b01;
                        trmt       <= 1'b1;
                        tx_data    <= win_cmd;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // tx_done was cleared by the UART on the trmt edge, so a 1 here is fresh.
                    if (tx_done) begin
                        if (byte_idx == PKT_LAST) begin
                            cmplt <= owner ? 2'b10 : 2'b01;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            trmt     <= 1'b1;
                            tx_data  <= next_byte;
                            state    <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: random/directed clients, behavioural UART, packet-level model.
module tb_uart_tx_arb;

`ifdef UART_ARB_CKSUM_EN
    localparam int PKT_LEN = 3;
`else
    localparam int PKT_LEN = 2;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] c_cmd [2];
    logic [7:0] c_data [2];
    logic [1:0] gnt;
    logic [1:0] cmplt;
    logic       busy;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;

    int n_vec = 0;
    int n_err = 0;

    bit rand_en = 0;
    bit hold_all = 0;

    // Scoreboard / model state (owned by the monitor)
    logic [7:0] exp_q[$];
    int         own_log[$];
    int         bytes_left = 0;
    int         bytes_sent = 0;
    int         cur_owner = 0;
    int         pkts = 0;
    bit         waiting = 0;
    bit         exp_trmt = 0;
    bit         exp_cmplt = 0;
    bit         idle = 1;
    bit         last_m = 1;
    logic [1:0] req_p = 2'b00;
    logic [7:0] cmd_p [2];
    logic [7:0] data_p [2];

    uart_tx_arb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .cmd0    (c_cmd[0]),
        .data0   (c_data[0]),
        .cmd1    (c_cmd[1]),
        .data1   (c_data[1]),
        .gnt     (gnt),
        .cmplt   (cmplt),
        .busy    (busy),
        .trmt    (trmt),
        .tx_data (tx_data),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART model: clears tx_done on the edge that takes trmt, sets it 1..6 cycles later.
    initial begin
        int d;
        tx_done = 1'b1;
        forever begin
            @(negedge clk);
            if (trmt === 1'b1 && rst_n === 1'b1) begin
                @(posedge clk);
                #1 tx_done = 1'b0;
                d = $urandom_range(1, 6);
                repeat (d) @(posedge clk);
                #1 tx_done = 1'b1;
            end
        end
    end

    // Monitor: predicts grants from the spec's round-robin rule and checks the byte stream.
    always @(negedge clk) begin
        logic [1:0] eg;
        logic [7:0] exp_b;
        bit         idle_n;
        bit         had_exp_trmt;
        int         w;
        if (!rst_n) begin
            exp_q.delete();
            bytes_left = 0;
            waiting    = 0;
            exp_trmt   = 0;
            exp_cmplt  = 0;
            idle       = 1;
            last_m     = 1;
            req_p      = 2'b00;
        end else begin
            eg = 2'b00;
            if (idle && req_p != 2'b00)
                eg = (req_p == 2'b11) ? (last_m ? 2'b01 : 2'b10) : req_p;
            if (eg != 2'b00 || gnt != 2'b00) chk("gnt", {6'd0, gnt}, {6'd0, eg});
            idle_n = idle;
            if (gnt != 2'b00) begin
                w = (eg != 2'b00) ? int'(eg[1]) : int'(gnt[1]);
                exp_q.push_back(cmd_p[w]);
                exp_q.push_back(data_p[w]);
                if (PKT_LEN == 3) exp_q.push_back(8'(cmd_p[w] + data_p[w]));
                bytes_left = PKT_LEN;
                bytes_sent = 0;
                cur_owner  = w;
                last_m     = w[0];
                idle_n     = 0;
                own_log.push_back(w);
                chk("gnt_with_trmt", {7'd0, trmt}, 8'd1);
            end
            if (exp_cmplt) begin
                chk("cmplt", {6'd0, cmplt}, (cur_owner == 1) ? 8'd2 : 8'd1);
                idle_n = 1;
                pkts++;
            end else if (cmplt != 2'b00) begin
                chk("cmplt_spurious", {6'd0, cmplt}, 8'd0);
            end
            exp_cmplt = 0;
            had_exp_trmt = exp_trmt;
            exp_trmt = 0;
            if (had_exp_trmt) chk("trmt_after_done", {7'd0, trmt}, 8'd1);
            if (trmt) begin
                if (gnt == 2'b00 && !had_exp_trmt) chk("trmt_spurious", {7'd0, trmt}, 8'd0);
                if (exp_q.size() == 0) begin
                    chk("tx_data_unexpected", tx_data, 8'hxx);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("tx_data", tx_data, exp_b);
                end
                bytes_left--;
                bytes_sent++;
                waiting = 1;
            end else if (waiting && tx_done) begin
                waiting = 0;
                if (bytes_left <= 0) exp_cmplt = 1;
                else exp_trmt = 1;
            end
            chk("busy", {7'd0, busy}, {7'd0, !idle_n});
            idle = idle_n;
        end
        req_p     = req;
        cmd_p[0]  = c_cmd[0];
        cmd_p[1]  = c_cmd[1];
        data_p[0] = c_data[0];
        data_p[1] = c_data[1];
    end

    // One clock of client behaviour: drop (or renew) req on gnt and scramble the source bytes.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i]) begin
                if (hold_all) begin
                    c_cmd[i]  = 8'($urandom);
                    c_data[i] = 8'($urandom);
                end else begin
                    req[i]    = 1'b0;
                    c_cmd[i]  = 8'hFF;
                    c_data[i] = ~c_data[i];
                end
            end else if (rand_en) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    c_cmd[i]  = 8'($urandom);
                    c_data[i] = 8'($urandom);
                    req[i]    = 1'b1;
                end else if (req[i] && $urandom_range(0, 31) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!(idle && exp_q.size() == 0 && req == 2'b00 && !exp_cmplt && !exp_trmt && !waiting)
               && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: timeout after %0d cycles, queue=%0d", n, exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, {6'd0, gnt}, 8'd0);
        chk({tag, "_cmplt"}, {6'd0, cmplt}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_trmt"}, {7'd0, trmt}, 8'd0);
        chk({tag, "_tx_data"}, tx_data, 8'h00);
    endtask

    initial begin
        int n;
        int p0;
        int o0;
        rst_n = 1'b0;
        req = 2'b00;
        c_cmd[0] = 8'h00; c_data[0] = 8'h00;
        c_cmd[1] = 8'h00; c_data[1] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single client
        c_cmd[0] = 8'hA5; c_data[0] = 8'h3C; req = 2'b01;
        wait_idle(200);

        // Tie from reset, then reset again to restore last_owner
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        c_cmd[0] = 8'h11; c_data[0] = 8'h22;
        c_cmd[1] = 8'h33; c_data[1] = 8'h44;
        req = 2'b11;
        tick();
        chk("tie_first_gnt", {6'd0, gnt}, 8'd1);
        wait_idle(300);

        // Fairness: both held over 4 packets
        p0 = pkts;
        o0 = own_log.size();
        hold_all = 1;
        c_cmd[0] = 8'h5A; c_data[0] = 8'h01;
        c_cmd[1] = 8'hC3; c_data[1] = 8'h02;
        req = 2'b11;
        n = 0;
        while (pkts < p0 + 4 && n < 2000) begin tick(); n++; end
        hold_all = 0;
        req = 2'b00;
        wait_idle(300);
        for (int i = o0 + 1; i < o0 + 4 && i < own_log.size(); i++)
            chk("fair_alternate", (own_log[i] != own_log[i-1]) ? 8'd1 : 8'd0, 8'd1);

        // Checksum-style packet
        c_cmd[0] = 8'hF0; c_data[0] = 8'h20; req = 2'b01;
        wait_idle(300);

        // Reset during the byte-1 WAIT
        c_cmd[0] = 8'h5A; c_data[0] = 8'h11; req = 2'b01;
        n = 0;
        while (bytes_sent < 2 && n < 200) begin tick(); n++; end
        if (n >= 200) chk("reach_byte1_timeout", 8'd1, 8'd0);
        rst_n = 1'b0;
        #1 check_reset_outputs("midwait");
        req = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        c_cmd[0] = 8'h77; c_data[0] = 8'h12; req = 2'b01;
        wait_idle(300);

        // Random traffic
        rand_en = 1;
        repeat (3000) tick();
        rand_en = 0;
        req = 2'b00;
        wait_idle(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
